segre_mem_arbiter: RTL and testbench
====================================

Name: segre_mem_arbiter

Overview:
- Sequences all main-memory traffic between the instruction cache (line fills) and the data cache (line fills and write-backs).
- Sits between both caches and the single main-memory port, and replaces the ad-hoc combinational IC/DC select.
- Allows one outstanding memory transaction at a time.
- IC has priority; a starvation counter forces a DC grant after STARVE_LIMIT consecutive IC wins while DC waits.

Parameters:
ADDR_SIZE, 32, byte address width
LINE_SIZE, 128, cache line width in bits
STARVE_LIMIT, 4, consecutive IC grants with DC pending before DC is forced (>=1)

Ports:
clk_i  in  1  clock, rising edge
rsn_i  in  1  asynchronous active-low reset
ic_req_i  in  1  IC miss request; held high until ic_rsp_valid_o
ic_addr_i  in  ADDR_SIZE  IC line address
ic_gnt_o  out  1  one-cycle pulse: IC request accepted
ic_rsp_valid_o  out  1  IC fill data valid (one cycle)
ic_rsp_data_o  out  LINE_SIZE  IC fill data
dc_req_i  in  1  DC request; held high until dc_rsp_valid_o
dc_we_i  in  1  1 = write-back, 0 = fill
dc_addr_i  in  ADDR_SIZE  DC line address
dc_wdata_i  in  LINE_SIZE  DC write-back data
dc_gnt_o  out  1  one-cycle pulse: DC request accepted
dc_rsp_valid_o  out  1  DC fill data / write ack valid (one cycle)
dc_rsp_data_o  out  LINE_SIZE  DC fill data
mem_req_o  out  1  memory request valid
mem_we_o  out  1  memory write
mem_addr_o  out  ADDR_SIZE  memory address
mem_wdata_o  out  LINE_SIZE  memory write data
mem_ready_i  in  1  memory accepts request this cycle
mem_rsp_valid_i  in  1  memory response (read data or write ack), one cycle
mem_rsp_data_i  in  LINE_SIZE  memory read data
sel_mem_req_o  out  1  current owner: 0 = IC, 1 = DC
busy_o  out  1  transaction in flight

Behaviour:
- Reset: one clock; rsn_i is asynchronous, active-low. On assertion, at any time:
  - FSM goes to IDLE and the starvation counter clears.
  - All registered outputs go to 0.
  - Any in-flight transaction is abandoned; memory is reset by the same rsn_i.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE arbitration, evaluated each cycle on the eligible requests:
  - A request is eligible if its req_i is high and it is not the requester served in the previous cycle (one-cycle mask after a response).
  - Only IC eligible -> grant IC.
  - Only DC eligible -> grant DC.
  - Both eligible -> grant DC if starve_cnt == STARVE_LIMIT, else IC.
- On a grant:
  - Register owner, address, we and wdata. IC we is forced to 0.
  - Next cycle the FSM is in ISSUE, the winner's gnt_o is high for exactly that cycle, and mem_req_o = 1.
  - Grant latency: req seen in cycle T -> gnt_o and mem_req_o in cycle T+1.
- ISSUE:
  - mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o stay stable until mem_ready_i = 1.
  - On mem_ready_i = 1 go to WAIT; mem_req_o drops the following cycle.
  - mem_rsp_valid_i in the same cycle as mem_ready_i is legal: treat as immediate completion.
- WAIT: on mem_rsp_valid_i = 1, in the same cycle:
  - Drive the owner's rsp_valid_o = 1 and rsp_data_o = mem_rsp_data_i (combinational route).
  - Next state is IDLE, with the served requester masked for that first IDLE cycle.
  - Non-owner rsp_valid_o stays 0. rsp_data_o is 0 when rsp_valid_o = 0.
- mem_rsp_valid_i in IDLE: ignored, no rsp_valid_o. In ISSUE it is ignored unless mem_ready_i is also high that cycle (the immediate-completion case above).
- Starvation counter (saturating, $clog2(STARVE_LIMIT+1) bits):
  - Increments on each IC grant made while dc_req_i is eligible.
  - Clears on every DC grant.
  - Saturates at STARVE_LIMIT.
- sel_mem_req_o = registered owner; it holds its value through IDLE.
- busy_o = 1 in ISSUE and WAIT.
- Requests: addr/we/wdata are sampled only at the grant; later changes are ignored. Requesters must not drop req_i before their response; if one does, the transaction still completes and the response is still driven.
- Back-to-back: minimum cycles between a response and the next issue to memory = 1 (IDLE arbitration cycle).

Test Plan:
- Reset, then IC alone: ic_req_i = 1 at T, addr 0x100 -> ic_gnt_o and mem_req_o at T+1 with mem_addr_o = 0x100 and mem_we_o = 0; mem_ready_i at T+1, mem_rsp_valid_i at T+4 with data 0xA5.. -> ic_rsp_valid_o = 1 at T+4, dc_rsp_valid_o = 0.
- Simultaneous IC and DC requests with STARVE_LIMIT = 4, IC re-requesting continuously -> IC wins 4 transactions, 5th grant goes to DC (sel_mem_req_o = 1), starve_cnt returns to 0.
- DC write-back (dc_we_i = 1, wdata 0xDEADBEEF..) with mem_ready_i low for 3 cycles -> mem_req_o, mem_addr_o and mem_wdata_o stable for all 3 cycles; write ack routed to dc_rsp_valid_o.
- Same-cycle mem_ready_i and mem_rsp_valid_i in ISSUE -> response delivered that cycle, FSM in IDLE next cycle, busy_o low.
- rsn_i asserted asynchronously mid-WAIT -> all outputs 0 immediately; a later stray mem_rsp_valid_i in IDLE produces no rsp_valid_o.
- Served-requester mask: IC holds ic_req_i one extra cycle after its response while DC is pending -> DC granted next, no duplicate IC grant.

Source files
------------

// File: rtl/segre_mem_arbiter.sv
// segre_mem_arbiter: serialises IC/DC line traffic onto one memory port, IC first with a DC starvation guard
module segre_mem_arbiter #(
   parameter int ADDR_SIZE    = 32,
   parameter int LINE_SIZE    = 128,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                 clk_i,
   input  logic                 rsn_i,
   input  logic                 ic_req_i,
   input  logic [ADDR_SIZE-1:0] ic_addr_i,
   output logic                 ic_gnt_o,
   output logic                 ic_rsp_valid_o,
   output logic [LINE_SIZE-1:0] ic_rsp_data_o,
   input  logic                 dc_req_i,
   input  logic                 dc_we_i,
   input  logic [ADDR_SIZE-1:0] dc_addr_i,
   input  logic [LINE_SIZE-1:0] dc_wdata_i,
   output logic                 dc_gnt_o,
   output logic                 dc_rsp_valid_o,
   output logic [LINE_SIZE-1:0] dc_rsp_data_o,
   output logic                 mem_req_o,
   output logic                 mem_we_o,
   output logic [ADDR_SIZE-1:0] mem_addr_o,
   output logic [LINE_SIZE-1:0] mem_wdata_o,
   input  logic                 mem_ready_i,
   input  logic                 mem_rsp_valid_i,
   input  logic [LINE_SIZE-1:0] mem_rsp_data_i,
   output logic                 sel_mem_req_o,
   output logic                 busy_o
);
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
   state_t               state_q, state_d;
   logic                 owner_q, owner_d;
   logic                 gnt_q, gnt_d;
   logic                 we_q, we_d;
   logic [ADDR_SIZE-1:0] addr_q, addr_d;
   logic [LINE_SIZE-1:0] wdata_q, wdata_d;
   logic [CW-1:0]        starve_q, starve_d;
   logic                 mask_ic_q, mask_ic_d;
   logic                 mask_dc_q, mask_dc_d;
   logic                 ic_el, dc_el, pick_dc, done;
   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         state_q   <= IDLE;
         owner_q   <= 1'b0;
         gnt_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         starve_q  <= '0;
         mask_ic_q <= 1'b0;
         mask_dc_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         gnt_q     <= gnt_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         starve_q  <= starve_d;
         mask_ic_q <= mask_ic_d;
         mask_dc_q <= mask_dc_d;
      end
   end
   // the requester served last cycle sits out one arbitration round
   always_comb begin
      ic_el     = ic_req_i & ~mask_ic_q;
      dc_el     = dc_req_i & ~mask_dc_q;
      pick_dc   = dc_el & (~ic_el | (starve_q == CW'(STARVE_LIMIT)));
      done      = mem_rsp_valid_i & ((state_q == WAIT) | ((state_q == ISSUE) & mem_ready_i));
      state_d   = state_q;
      owner_d   = owner_q;
      gnt_d     = 1'b0;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      starve_d  = starve_q;
      mask_ic_d = done & ~owner_q;
      mask_dc_d = done & owner_q;
      case (state_q)
         IDLE: if (ic_el | dc_el) begin
            state_d  = ISSUE;
            owner_d  = pick_dc;
            gnt_d    = 1'b1;
            we_d     = pick_dc & dc_we_i;
            addr_d   = pick_dc ? dc_addr_i : ic_addr_i;
            wdata_d  = pick_dc ? dc_wdata_i : '0;
            starve_d = pick_dc ? '0 :
                       (dc_el && starve_q != CW'(STARVE_LIMIT)) ? starve_q + CW'(1) : starve_q;
         end
         ISSUE: if (mem_ready_i) state_d = mem_rsp_valid_i ? IDLE : WAIT;
         WAIT: if (mem_rsp_valid_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   assign ic_gnt_o       = gnt_q & ~owner_q;
   assign dc_gnt_o       = gnt_q & owner_q;
   assign ic_rsp_valid_o = done & ~owner_q;
   assign dc_rsp_valid_o = done & owner_q;
   assign ic_rsp_data_o  = ic_rsp_valid_o ? mem_rsp_data_i : '0;
   assign dc_rsp_data_o  = dc_rsp_valid_o ? mem_rsp_data_i : '0;
   assign mem_req_o      = state_q == ISSUE;
   assign mem_we_o       = we_q;
   assign mem_addr_o     = addr_q;
   assign mem_wdata_o    = wdata_q;
   assign sel_mem_req_o  = owner_q;
   assign busy_o         = state_q != IDLE;
endmodule

// File: tb/tb_segre_mem_arbiter.sv
// tb_segre_mem_arbiter: directed scenarios plus randomized traffic against a cycle-level reference model
module tb_segre_mem_arbiter;
   localparam int AW  = 32;
   localparam int LW  = 128;
   localparam int LIM = 4;

   logic          clk_i = 1'b0;
   logic          rsn_i = 1'b0;
   logic          ic_req_i = 1'b0;
   logic [AW-1:0] ic_addr_i = '0;
   logic          ic_gnt_o, ic_rsp_valid_o;
   logic [LW-1:0] ic_rsp_data_o;
   logic          dc_req_i = 1'b0;
   logic          dc_we_i = 1'b0;
   logic [AW-1:0] dc_addr_i = '0;
   logic [LW-1:0] dc_wdata_i = '0;
   logic          dc_gnt_o, dc_rsp_valid_o;
   logic [LW-1:0] dc_rsp_data_o;
   logic          mem_req_o, mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [LW-1:0] mem_wdata_o;
   logic          mem_ready_i = 1'b0;
   logic          mem_rsp_valid_i = 1'b0;
   logic [LW-1:0] mem_rsp_data_i = '0;
   logic          sel_mem_req_o, busy_o;

   int vectors = 0;
   int errors  = 0;

   segre_mem_arbiter #(.ADDR_SIZE(AW), .LINE_SIZE(LW), .STARVE_LIMIT(LIM)) dut (
      .clk_i(clk_i), .rsn_i(rsn_i),
      .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_gnt_o(ic_gnt_o),
      .ic_rsp_valid_o(ic_rsp_valid_o), .ic_rsp_data_o(ic_rsp_data_o),
      .dc_req_i(dc_req_i), .dc_we_i(dc_we_i), .dc_addr_i(dc_addr_i), .dc_wdata_i(dc_wdata_i),
      .dc_gnt_o(dc_gnt_o), .dc_rsp_valid_o(dc_rsp_valid_o), .dc_rsp_data_o(dc_rsp_data_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_ready_i(mem_ready_i), .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_data_i(mem_rsp_data_i),
      .sel_mem_req_o(sel_mem_req_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic idle_inputs();
      ic_req_i = 0; dc_req_i = 0; dc_we_i = 0;
      mem_ready_i = 0; mem_rsp_valid_i = 0;
   endtask

   task automatic test_reset();
      logic [7:0] ctl;
      idle_inputs();
      rsn_i = 0;
      @(negedge clk_i); #1;
      ctl = {ic_gnt_o, dc_gnt_o, ic_rsp_valid_o, dc_rsp_valid_o, mem_req_o, mem_we_o, sel_mem_req_o, busy_o};
      vectors++;
      if (ctl !== 8'h00) begin errors++; $display("FAIL reset_ctl got=%h exp=00", ctl); end
      vectors++;
      if (mem_addr_o !== '0 || mem_wdata_o !== '0) begin
         errors++; $display("FAIL reset_mem addr=%h wdata=%h exp 0", mem_addr_o, mem_wdata_o);
      end
      @(negedge clk_i); rsn_i = 1;
      @(negedge clk_i); #1;
      vectors++;
      if (busy_o !== 0 || mem_req_o !== 0) begin
         errors++; $display("FAIL reset_idle busy=%b req=%b exp 0 0", busy_o, mem_req_o);
      end
   endtask

   task automatic test_ic_alone();
      @(negedge clk_i); ic_req_i = 1; ic_addr_i = 32'h100; #1;
      vectors++;
      if (ic_gnt_o !== 0 || mem_req_o !== 0) begin
         errors++; $display("FAIL ic_pre gnt=%b req=%b exp 0 0", ic_gnt_o, mem_req_o);
      end
      @(negedge clk_i); mem_ready_i = 1; ic_addr_i = 32'h999; #1;
      vectors++;
      if ({ic_gnt_o, dc_gnt_o, mem_req_o, mem_we_o, sel_mem_req_o, busy_o} !== 6'b101001 || mem_addr_o !== 32'h100) begin
         errors++; $display("FAIL ic_grant ctl=%b addr=%h exp 101001 100",
            {ic_gnt_o, dc_gnt_o, mem_req_o, mem_we_o, sel_mem_req_o, busy_o}, mem_addr_o);
      end
      @(negedge clk_i); mem_ready_i = 0; #1;
      vectors++;
      if (mem_req_o !== 0 || ic_gnt_o !== 0 || busy_o !== 1) begin
         errors++; $display("FAIL ic_wait req=%b gnt=%b busy=%b exp 0 0 1", mem_req_o, ic_gnt_o, busy_o);
      end
      @(negedge clk_i); #1;
      vectors++;
      if (ic_rsp_valid_o !== 0) begin errors++; $display("FAIL ic_early_rsp got=%b exp 0", ic_rsp_valid_o); end
      @(negedge clk_i); mem_rsp_valid_i = 1; mem_rsp_data_i = {4{32'hA5A5A5A5}}; #1;
      vectors++;
      if (ic_rsp_valid_o !== 1 || dc_rsp_valid_o !== 0 || ic_rsp_data_o !== {4{32'hA5A5A5A5}} || dc_rsp_data_o !== '0) begin
         errors++; $display("FAIL ic_rsp v=%b dv=%b data=%h exp 1 0 a5..", ic_rsp_valid_o, dc_rsp_valid_o, ic_rsp_data_o);
      end
      @(negedge clk_i); mem_rsp_valid_i = 0; ic_req_i = 0; #1;
      vectors++;
      if (busy_o !== 0 || ic_rsp_valid_o !== 0) begin
         errors++; $display("FAIL ic_done busy=%b v=%b exp 0 0", busy_o, ic_rsp_valid_o);
      end
   endtask

   task automatic test_starvation();
      bit seq[$];
      bit exp_seq[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
      bit prev_rsp = 0;
      int cyc = 0;
      mem_ready_i = 1; dc_we_i = 0;
      while (seq.size() < 10 && cyc < 200) begin
         @(negedge clk_i);
         ic_req_i = !prev_rsp; dc_req_i = !prev_rsp;
         ic_addr_i = $urandom; dc_addr_i = $urandom;
         mem_rsp_valid_i = busy_o && !mem_req_o;
         #1;
         if (ic_gnt_o) seq.push_back(0);
         if (dc_gnt_o) begin
            seq.push_back(1);
            vectors++;
            if (sel_mem_req_o !== 1) begin errors++; $display("FAIL starve_sel got=%b exp 1", sel_mem_req_o); end
         end
         prev_rsp = ic_rsp_valid_o || dc_rsp_valid_o;
         cyc++;
      end
      vectors++;
      if (seq.size() < 10) begin errors++; $display("FAIL starve_timeout grants=%0d exp 10", seq.size()); end
      for (int i = 0; i < seq.size() && i < 10; i++) begin
         vectors++;
         if (seq[i] !== exp_seq[i]) begin errors++; $display("FAIL starve_seq[%0d] owner=%b exp %b", i, seq[i], exp_seq[i]); end
      end
      ic_req_i = 0; dc_req_i = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i); mem_rsp_valid_i = busy_o && !mem_req_o;
      end
      @(negedge clk_i); idle_inputs(); #1;
      vectors++;
      if (busy_o !== 0) begin errors++; $display("FAIL starve_drain busy=%b exp 0", busy_o); end
   endtask

   task automatic test_writeback_stall();
      @(negedge clk_i); dc_req_i = 1; dc_we_i = 1; dc_addr_i = 32'h2000; dc_wdata_i = {4{32'hDEADBEEF}}; #1;
      vectors++;
      if (mem_req_o !== 0) begin errors++; $display("FAIL wb_pre req=%b exp 0", mem_req_o); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i); dc_addr_i = $urandom; dc_wdata_i = {$urandom, $urandom, $urandom, $urandom};
         mem_ready_i = (i == 3); #1;
         vectors++;
         if (mem_req_o !== 1 || mem_we_o !== 1 || mem_addr_o !== 32'h2000 || mem_wdata_o !== {4{32'hDEADBEEF}}
             || dc_gnt_o !== (i == 0) || ic_gnt_o !== 0) begin
            errors++; $display("FAIL wb_stall[%0d] req=%b we=%b addr=%h wdata=%h gnt=%b exp 1 1 2000 deadbeef.. %b",
               i, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, dc_gnt_o, i == 0);
         end
      end
      @(negedge clk_i); mem_ready_i = 0; mem_rsp_valid_i = 1; #1;
      vectors++;
      if (dc_rsp_valid_o !== 1 || ic_rsp_valid_o !== 0) begin
         errors++; $display("FAIL wb_ack dv=%b iv=%b exp 1 0", dc_rsp_valid_o, ic_rsp_valid_o);
      end
      @(negedge clk_i); idle_inputs(); #1;
   endtask

   task automatic test_immediate();
      @(negedge clk_i); ic_req_i = 1; ic_addr_i = 32'h300;
      @(negedge clk_i); mem_ready_i = 1; mem_rsp_valid_i = 1; mem_rsp_data_i = {4{32'h12345678}}; #1;
      vectors++;
      if (ic_gnt_o !== 1 || ic_rsp_valid_o !== 1 || ic_rsp_data_o !== {4{32'h12345678}}) begin
         errors++; $display("FAIL imm_rsp gnt=%b v=%b data=%h exp 1 1 12345678..", ic_gnt_o, ic_rsp_valid_o, ic_rsp_data_o);
      end
      @(negedge clk_i); idle_inputs(); #1;
      vectors++;
      if (busy_o !== 0 || mem_req_o !== 0 || ic_rsp_valid_o !== 0) begin
         errors++; $display("FAIL imm_idle busy=%b req=%b v=%b exp 0 0 0", busy_o, mem_req_o, ic_rsp_valid_o);
      end
   endtask

   task automatic test_mask();
      @(negedge clk_i); ic_req_i = 1; ic_addr_i = 32'h500; dc_req_i = 1; dc_we_i = 0; dc_addr_i = 32'h400;
      @(negedge clk_i); mem_ready_i = 1; #1;
      vectors++;
      if (ic_gnt_o !== 1 || dc_gnt_o !== 0) begin errors++; $display("FAIL mask_first ig=%b dg=%b exp 1 0", ic_gnt_o, dc_gnt_o); end
      @(negedge clk_i); mem_ready_i = 0; mem_rsp_valid_i = 1; #1;
      vectors++;
      if (ic_rsp_valid_o !== 1) begin errors++; $display("FAIL mask_ic_rsp got=%b exp 1", ic_rsp_valid_o); end
      @(negedge clk_i); mem_rsp_valid_i = 0; #1;
      vectors++;
      if (ic_gnt_o !== 0 || dc_gnt_o !== 0 || busy_o !== 0) begin
         errors++; $display("FAIL mask_gap ig=%b dg=%b busy=%b exp 0 0 0", ic_gnt_o, dc_gnt_o, busy_o);
      end
      @(negedge clk_i); ic_req_i = 0; mem_ready_i = 1; #1;
      vectors++;
      if (dc_gnt_o !== 1 || ic_gnt_o !== 0 || sel_mem_req_o !== 1 || mem_addr_o !== 32'h400) begin
         errors++; $display("FAIL mask_dc_grant dg=%b ig=%b sel=%b addr=%h exp 1 0 1 400", dc_gnt_o, ic_gnt_o, sel_mem_req_o, mem_addr_o);
      end
      @(negedge clk_i); mem_ready_i = 0; mem_rsp_valid_i = 1; #1;
      vectors++;
      if (dc_rsp_valid_o !== 1 || ic_rsp_valid_o !== 0) begin
         errors++; $display("FAIL mask_dc_rsp dv=%b iv=%b exp 1 0", dc_rsp_valid_o, ic_rsp_valid_o);
      end
      @(negedge clk_i); idle_inputs(); #1;
   endtask

   task automatic test_async_reset();
      @(negedge clk_i); dc_req_i = 1; dc_we_i = 0; dc_addr_i = 32'h600;
      @(negedge clk_i); mem_ready_i = 1;
      @(negedge clk_i); mem_ready_i = 0; #1;
      vectors++;
      if (busy_o !== 1 || mem_req_o !== 0) begin errors++; $display("FAIL ar_wait busy=%b req=%b exp 1 0", busy_o, mem_req_o); end
      #1 rsn_i = 0;
      #1;
      vectors++;
      if ({busy_o, mem_req_o, sel_mem_req_o, dc_gnt_o, dc_rsp_valid_o, ic_rsp_valid_o, mem_we_o} !== 7'b0 || mem_addr_o !== '0) begin
         errors++; $display("FAIL ar_clear ctl=%b addr=%h exp 0 0",
            {busy_o, mem_req_o, sel_mem_req_o, dc_gnt_o, dc_rsp_valid_o, ic_rsp_valid_o, mem_we_o}, mem_addr_o);
      end
      @(negedge clk_i); dc_req_i = 0;
      @(negedge clk_i); rsn_i = 1;
      @(negedge clk_i); mem_rsp_valid_i = 1; #1;
      vectors++;
      if (dc_rsp_valid_o !== 0 || ic_rsp_valid_o !== 0 || busy_o !== 0) begin
         errors++; $display("FAIL ar_stray dv=%b iv=%b busy=%b exp 0 0 0", dc_rsp_valid_o, ic_rsp_valid_o, busy_o);
      end
      @(negedge clk_i); idle_inputs();
   endtask

   task automatic test_random();
      int m_st = 0, m_starve = 0, m_mask = -1;
      bit m_first = 0, m_owner = 0, m_we = 0;
      logic [AW-1:0] m_addr = '0;
      logic [LW-1:0] m_wdata = '0;
      bit ic_pend = 0, dc_pend = 0;
      bit ic_el, dc_el, pick_dc, e_done;
      logic [6:0] e_ctl, got_ctl;
      logic [LW-1:0] e_idata, e_ddata;
      @(negedge clk_i); idle_inputs(); rsn_i = 0;
      @(negedge clk_i); rsn_i = 1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk_i);
         if (!ic_pend) begin ic_req_i = $urandom_range(0, 1); ic_pend = ic_req_i; end
         if (!dc_pend) begin dc_req_i = $urandom_range(0, 2) != 0; dc_pend = dc_req_i; end
         ic_addr_i = $urandom; dc_addr_i = $urandom; dc_we_i = $urandom_range(0, 1);
         dc_wdata_i = {$urandom, $urandom, $urandom, $urandom};
         mem_ready_i = $urandom_range(0, 1);
         mem_rsp_valid_i = $urandom_range(0, 2) == 0;
         mem_rsp_data_i = {$urandom, $urandom, $urandom, $urandom};
         #1;
         e_done = mem_rsp_valid_i && (m_st == 2 || (m_st == 1 && mem_ready_i));
         e_ctl = {m_st == 1 && m_first && !m_owner, m_st == 1 && m_first && m_owner, m_st == 1, m_st != 0,
                  m_owner, e_done && !m_owner, e_done && m_owner};
         got_ctl = {ic_gnt_o, dc_gnt_o, mem_req_o, busy_o, sel_mem_req_o, ic_rsp_valid_o, dc_rsp_valid_o};
         e_idata = (e_done && !m_owner) ? mem_rsp_data_i : '0;
         e_ddata = (e_done && m_owner) ? mem_rsp_data_i : '0;
         vectors++;
         if (got_ctl !== e_ctl) begin errors++; $display("FAIL rnd_ctl cyc=%0d got=%b exp=%b", cyc, got_ctl, e_ctl); end
         vectors++;
         if (ic_rsp_data_o !== e_idata || dc_rsp_data_o !== e_ddata) begin
            errors++; $display("FAIL rnd_data cyc=%0d ic=%h dc=%h exp %h %h", cyc, ic_rsp_data_o, dc_rsp_data_o, e_idata, e_ddata);
         end
         if (m_st == 1) begin
            vectors++;
            if (mem_addr_o !== m_addr || mem_we_o !== m_we || (m_we && mem_wdata_o !== m_wdata)) begin
               errors++; $display("FAIL rnd_mem cyc=%0d addr=%h we=%b wdata=%h exp %h %b %h",
                  cyc, mem_addr_o, mem_we_o, mem_wdata_o, m_addr, m_we, m_wdata);
            end
         end
         if (e_done && !m_owner) ic_pend = 0;
         if (e_done && m_owner) dc_pend = 0;
         m_first = 0;
         if (m_st == 0) begin
            ic_el = ic_req_i && m_mask != 0;
            dc_el = dc_req_i && m_mask != 1;
            pick_dc = dc_el && (!ic_el || m_starve == LIM);
            if (ic_el || dc_el) begin
               m_st = 1; m_first = 1; m_owner = pick_dc;
               m_addr = pick_dc ? dc_addr_i : ic_addr_i;
               m_we = pick_dc && dc_we_i;
               m_wdata = dc_wdata_i;
               if (pick_dc) m_starve = 0;
               else if (dc_el && m_starve < LIM) m_starve++;
            end
         end else if (m_st == 1) begin
            if (mem_ready_i) m_st = mem_rsp_valid_i ? 0 : 2;
         end else if (mem_rsp_valid_i) m_st = 0;
         m_mask = e_done ? int'(m_owner) : -1;
      end
      @(negedge clk_i); idle_inputs();
   endtask

   initial begin
      test_reset();
      test_ic_alone();
      test_starvation();
      test_writeback_stall();
      test_immediate();
      test_mask();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
